hamming74_serial_checker: RTL and testbench



---
 rtl/hamming74_serial_checker.sv | 68 ++++++
 tb/tb_hamming74_serial_checker.sv | 130 +++++++++++++
 2 files changed

// File: rtl/hamming74_serial_checker.sv
// hamming74_serial_checker: serial Hamming(7,4) receiver with single-bit correction and error counter
module hamming74_serial_checker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       sync,
  input  logic       cnt_clr,
  output logic [2:0] sin,
  output logic [3:0] data_out,
  output logic       err,
  output logic       out_valid,
  output logic [7:0] err_count
);
  typedef enum logic {COLLECT, EVAL} state_t;
  state_t     state_q, state_d;
  logic [7:1] code_q, code_d, fixed;
  logic [2:0] pos_q, pos_d, p, syn, sin_q, sin_d;
  logic [3:0] data_q, data_d;
  logic       err_q, err_d, ov_q, ov_d, ev;
  logic [7:0] cnt_q, cnt_d, flip;
  logic [6:0] mask;
  always_comb begin
    ev = state_q == EVAL;
    syn = {code_q[4] ^ code_q[5] ^ code_q[6] ^ code_q[7],
           code_q[2] ^ code_q[3] ^ code_q[6] ^ code_q[7],
           code_q[1] ^ code_q[3] ^ code_q[5] ^ code_q[7]};
    // flip[0] absorbs the clean case so no bit of the word is touched
    flip = 8'b1 << syn;
    fixed = code_q ^ flip[7:1];
    p = sync ? 3'd0 : pos_q;
    mask = 7'b1 << p;
    code_d = bit_valid ? ((code_q & ~mask) | (bit_in ? mask : 7'b0)) : code_q;
    pos_d = bit_valid ? ((p == 3'd6) ? 3'd0 : p + 3'd1) : p;
    state_d = (bit_valid && p == 3'd6) ? EVAL : COLLECT;
    sin_d = ev ? syn : sin_q;
    data_d = ev ? {fixed[7], fixed[6], fixed[5], fixed[3]} : data_q;
    err_d = ev ? (syn != 3'd0) : err_q;
    ov_d = ev;
    cnt_d = cnt_clr ? 8'd0 : (ev && syn != 3'd0 && cnt_q != 8'd255) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      code_q <= '0;
      pos_q <= '0;
      sin_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      ov_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      pos_q <= pos_d;
      sin_q <= sin_d;
      data_q <= data_d;
      err_q <= err_d;
      ov_q <= ov_d;
      cnt_q <= cnt_d;
    end
  end
  assign sin = sin_q;
  assign data_out = data_q;
  assign err = err_q;
  assign out_valid = ov_q;
  assign err_count = cnt_q;
endmodule

// File: tb/tb_hamming74_serial_checker.sv
// tb_hamming74_serial_checker: directed and random stimulus against a positional-XOR Hamming model
module tb_hamming74_serial_checker;
  logic clk = 0, rst_n = 0, bit_in = 0, bit_valid = 0, sync = 0, cnt_clr = 0;
  logic [2:0] sin;
  logic [3:0] data_out;
  logic err, out_valid;
  logic [7:0] err_count;
  int total = 0, passed = 0, ov_seen;
  logic [2:0] m_sin;
  logic [3:0] m_data;
  logic m_err, m_ov, pend;
  int m_cnt, n;
  logic [7:1] mword, pword;
  localparam logic [7:1] CLEAN = 7'b1010101, ERR5 = 7'b1000101, ERR1 = 7'b1010100;

  hamming74_serial_checker dut (.clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .sync(sync), .cnt_clr(cnt_clr), .sin(sin), .data_out(data_out), .err(err),
    .out_valid(out_valid), .err_count(err_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // syndrome = XOR of the indices of all set bits; flip that index to correct
  task automatic evaluate(input logic [7:1] w);
    int s;
    s = 0;
    for (int i = 1; i <= 7; i++) if (w[i]) s ^= i;
    if (s != 0) w[s] = ~w[s];
    m_sin = 3'(s);
    m_err = s != 0;
    m_data = {w[7], w[6], w[5], w[3]};
  endtask

  task automatic step(input logic rn, input logic bv, input logic b, input logic sy, input logic clr);
    rst_n = rn; bit_valid = bv; bit_in = b; sync = sy; cnt_clr = clr;
    @(posedge clk);
    if (!rn) begin
      m_sin = 0; m_data = 0; m_err = 0; m_ov = 0; m_cnt = 0; n = 0; pend = 0; mword = 0;
    end else begin
      m_ov = pend;
      if (pend) evaluate(pword);
      m_cnt = clr ? 0 : (pend && m_err && m_cnt < 255) ? m_cnt + 1 : m_cnt;
      if (sy) n = 0;
      if (bv) begin mword[n + 1] = b; n++; end
      pend = 0;
      if (n == 7) begin pend = 1; pword = mword; n = 0; end
    end
    #1;
    if (out_valid) ov_seen++;
    chk("out_valid", 8'(out_valid), 8'(m_ov));
    chk("sin", 8'(sin), 8'(m_sin));
    chk("data_out", 8'(data_out), 8'(m_data));
    chk("err", 8'(err), 8'(m_err));
    chk("err_count", err_count, 8'(m_cnt));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic send(input logic [7:1] c, input int gap);
    for (int i = 1; i <= 7; i++) begin
      step(1, 1, c[i], 0, 0);
      if (i < 7) idle(gap);
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0);
    chk("reset_sin", 8'(sin), 8'd0);
    chk("reset_cnt", err_count, 8'd0);
    send(CLEAN, 0); step(1, 0, 0, 0, 0);
    chk("clean_ov", 8'(out_valid), 8'd1);
    chk("clean_data", 8'(data_out), 8'hb);
    chk("clean_sin", 8'(sin), 8'd0);
    send(ERR5, 0); step(1, 0, 0, 0, 0);
    chk("d5_sin", 8'(sin), 8'd5);
    chk("d5_data", 8'(data_out), 8'hb);
    chk("d5_cnt", err_count, 8'd1);
    send(ERR1, 0); step(1, 0, 0, 0, 0);
    chk("p1_sin", 8'(sin), 8'd1);
    chk("p1_err", 8'(err), 8'd1);
    send(ERR5, 0);
    ov_seen = 0;
    for (int i = 1; i <= 4; i++) step(1, 1, CLEAN[i], 0, 0);
    step(1, 1, CLEAN[1], 1, 0);
    for (int i = 2; i <= 7; i++) step(1, 1, CLEAN[i], 0, 0);
    idle(3);
    chk("sync_ov_count", 8'(ov_seen), 8'd2);
    chk("sync_sin", 8'(sin), 8'd0);
    ov_seen = 0;
    for (int i = 1; i <= 6; i++) step(1, 1, ERR5[i], 0, 0);
    step(1, 1, ERR5[7], 1, 0);
    for (int i = 2; i <= 6; i++) step(1, 1, ERR5[i], 0, 0);
    step(1, 1, ERR5[7], 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("sync_c7_ov_count", 8'(ov_seen), 8'd1);
    chk("sync_eval_sin", 8'(sin), 8'd5);
    ov_seen = 0;
    send(CLEAN, 3);
    chk("gap_no_early_ov", 8'(ov_seen), 8'd0);
    step(1, 0, 0, 0, 0);
    chk("gap_ov_count", 8'(ov_seen), 8'd1);
    chk("gap_sin", 8'(sin), 8'd0);
    step(1, 0, 0, 0, 1);
    for (int w = 0; w < 260; w++) send(ERR5, 0);
    idle(2);
    chk("sat_cnt", err_count, 8'd255);
    send(ERR5, 0); step(1, 0, 0, 0, 1);
    chk("clr_in_eval_ov", 8'(out_valid), 8'd1);
    chk("clr_in_eval_cnt", err_count, 8'd0);
    for (int i = 1; i <= 4; i++) step(1, 1, ERR5[i], 0, 0);
    step(0, 0, 0, 0, 0);
    send(CLEAN, 0); step(1, 0, 0, 0, 0);
    chk("rst_mid_sin", 8'(sin), 8'd0);
    for (int i = 0; i < 4000; i++)
      step(($urandom % 500) != 0, ($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0,
           ($urandom % 60) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
